// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline hazard controller and its clients.
//   master : side that raises stall/hold/flush requests and consumes the
//            stall/bubble/flush/redirect results (core glue, testbench)
//   slave  : the hazard controller itself
// Signals
//   stall_req [NUM_SRC]  level stall requests, one per source
//   hold_req / hold_len  pulse plus length of a fixed multi-cycle hold
//   flush_req / flush_pc pulse plus redirect target
//   stall / bubble       per-stage stall vector and one-hot NOP insertion
//   flush / new_pc       registered flush strobe and redirect target
//   busy / wdog_err      sequence in progress, sticky watchdog error
interface pipe_hazard_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int STALL_W = 6,
  parameter int HOLD_W  = 6
);
  logic [NUM_SRC-1:0] stall_req;
  logic               hold_req;
  logic [HOLD_W-1:0]  hold_len;
  logic               flush_req;
  logic [31:0]        flush_pc;
  logic [STALL_W-1:0] stall;
  logic [STALL_W-1:0] bubble;
  logic               flush;
  logic [31:0]        new_pc;
  logic               busy;
  logic               wdog_err;

  modport master (
    output stall_req, hold_req, hold_len, flush_req, flush_pc,
    input  stall, bubble, flush, new_pc, busy, wdog_err
  );

  modport slave (
    input  stall_req, hold_req, hold_len, flush_req, flush_pc,
    output stall, bubble, flush, new_pc, busy, wdog_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller for the 5-stage core (PC,IF,ID,EX,MEM,WB).
// Merges level stall requests into a prefix stall vector plus a one-hot
// bubble, runs fixed-length holds started by a pulse, and sequences
// registered flush/redirect strobes.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-low
//   bus  : pipe_hazard_ctrl_if.slave (requests in, stall/bubble/flush/
//          new_pc/busy/wdog_err out)
// Optional feature
//   STALL_WATCHDOG_EN : when defined, counts consecutive stalled cycles and
//                       sets a sticky wdog_err at WDOG_LIMIT; otherwise
//                       wdog_err is tied low.
module pipe_hazard_ctrl #(
  parameter int                     STALL_W    = 6,
  parameter int                     NUM_SRC    = 4,
  parameter logic [3*NUM_SRC-1:0]   SRC_STAGE  = 12'h31A,
  parameter int                     HOLD_STAGE = 3,
  parameter int                     HOLD_W     = 6,
  parameter int                     FLUSH_CYC  = 2,
  parameter int                     WDOG_LIMIT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int FC_W = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);

  if (FLUSH_CYC < 1 || WDOG_LIMIT < 1) begin : g_cfg_check
    $error("pipe_hazard_ctrl: FLUSH_CYC and WDOG_LIMIT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  rem, rem_nxt;
  logic [FC_W-1:0]    fcnt, fcnt_nxt;
  logic [31:0]        new_pc_q, new_pc_nxt;
  logic               flush_q;
  logic               hold_now;
  logic [STALL_W-1:0] stall_raw;
  logic [STALL_W-1:0] stall;

  // Mask covering stage s and every stage upstream of it.
  function automatic logic [STALL_W-1:0] stage_mask(input logic [2:0] s);
    logic [STALL_W-1:0] m;
    m = '0;
    for (int b = 0; b < STALL_W; b++) m[b] = (b <= int'(s));
    return m;
  endfunction

  // Hold is live in the pulse cycle itself (from IDLE) and for the whole
  // HOLD state; a zero length pulse never stalls.
  assign hold_now = (state == HOLD) ||
                    (state == IDLE && bus.hold_req && (bus.hold_len != '0));

  always_comb begin
    stall_raw = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.stall_req[i]) stall_raw = stall_raw | stage_mask(SRC_STAGE[3*i +: 3]);
    end
    if (hold_now) stall_raw = stall_raw | stage_mask(3'(HOLD_STAGE));
  end

  // The pipeline is being emptied during FLUSH, so stalls are meaningless.
  assign stall = (!rst || state == FLUSH) ? '0 : stall_raw;

  // stall is always a contiguous prefix from bit 0, so the stage just above
  // its top bit is (stall<<1) & ~stall; WB-level stalls shift out to 0.
  assign bus.stall  = stall;
  assign bus.bubble = (stall << 1) & ~stall;

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    fcnt_nxt   = fcnt;
    new_pc_nxt = new_pc_q;
    if (bus.flush_req) begin
      // Redirect wins over everything: abandons holds, drops a same-cycle
      // hold_req and restarts an ongoing flush with the newest target.
      state_nxt  = FLUSH;
      fcnt_nxt   = FC_W'(FLUSH_CYC);
      new_pc_nxt = bus.flush_pc;
      rem_nxt    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Length 1 is fully covered by the pulse cycle, no state needed.
          if (bus.hold_req && bus.hold_len > HOLD_W'(1)) begin
            state_nxt = HOLD;
            rem_nxt   = bus.hold_len - HOLD_W'(1);
          end
        end
        HOLD: begin
          if (rem == HOLD_W'(1)) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
          end else begin
            rem_nxt = rem - HOLD_W'(1);
          end
        end
        FLUSH: begin
          if (fcnt == FC_W'(1)) begin
            state_nxt = IDLE;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt - FC_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rem      <= '0;
      fcnt     <= '0;
      new_pc_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      fcnt     <= fcnt_nxt;
      new_pc_q <= new_pc_nxt;
      flush_q  <= (state_nxt == FLUSH);
    end
  end

  assign bus.flush  = flush_q;
  assign bus.new_pc = new_pc_q;
  assign bus.busy   = (state != IDLE);

`ifdef STALL_WATCHDOG_EN
  localparam int WC_W = $clog2(WDOG_LIMIT + 1);

  logic [WC_W-1:0] wcnt;
  logic            wdog_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt   <= '0;
      wdog_q <= 1'b0;
    end else if (stall == '0 || flush_q) begin
      wcnt <= '0;
    end else begin
      // Saturate so a very long stall cannot wrap back below the limit.
      if (wcnt != WC_W'(WDOG_LIMIT)) wcnt <= wcnt + WC_W'(1);
      if (wcnt == WC_W'(WDOG_LIMIT - 1)) wdog_q <= 1'b1;
    end
  end

  assign bus.wdog_err = wdog_q;
`else
  assign bus.wdog_err = 1'b0;
`endif

endmodule
